march_bist_ctrl: RTL

- March C- BIST sequencer that sits directly upstream of the BIST address generator (`Gen`).
- Drives the generator's reset, preset, enable and direction inputs, and consumes its address and terminal-count outputs.
- Issues read/write strobes and data backgrounds to the memory under test, and compares read data.
- Reports done, pass/fail and the first failing location.

---
 rtl/march_bist_ctrl.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/march_bist_ctrl.sv
// March C- BIST sequencer: drives the Gen address counter and memory strobes.
// Optional MARCH_ABORT_ON_FAIL_EN: jump to DONE on the first read mismatch.
module march_bist_ctrl #(
    parameter int ADR_SIZE = 4,
    parameter int DATA_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                adr_rst,
    output logic                adr_pr_rst,
    output logic                adr_en,
    output logic                adr_up_down,
    input  logic [ADR_SIZE-1:0] adr,
    input  logic                adr_c_out,
    output logic                mem_we,
    output logic                mem_re,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic                done,
    output logic                fail,
    output logic [ADR_SIZE-1:0] fail_adr,
    output logic [2:0]          fail_elem
);

`ifdef MARCH_ABORT_ON_FAIL_EN
    localparam logic ABORT_ON_FAIL = 1'b1;
`else
    localparam logic ABORT_ON_FAIL = 1'b0;
`endif

    localparam logic [2:0] LAST_ELEM = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_OP1,
        S_OP2,
        S_FLUSH,
        S_DONE
    } state_t;

    // E3 and E4 walk the array downwards, every other element upwards.
    function automatic logic el_up(input logic [2:0] e);
        return !(e == 3'd3 || e == 3'd4);
    endfunction

    // E0 (w0) and E5 (r0) carry a single op per address.
    function automatic logic el_single(input logic [2:0] e);
        return (e == 3'd0) || (e == 3'd5);
    endfunction

    // Only E0 opens with a write; all others open with a read.
    function automatic logic op1_rd(input logic [2:0] e);
        return e != 3'd0;
    endfunction

    // Background of the first op: r1 in E2/E4, otherwise 0.
    function automatic logic op1_bg(input logic [2:0] e);
        return (e == 3'd2) || (e == 3'd4);
    endfunction

    // Background of the second (write) op: w1 in E1/E3, w0 in E2/E4.
    function automatic logic op2_bg(input logic [2:0] e);
        return (e == 3'd1) || (e == 3'd3);
    endfunction

    state_t                state_q;
    state_t                state_d;
    logic [2:0]            elem_q;
    logic [2:0]            elem_d;

    logic                  adr_rst_q;
    logic                  adr_rst_d;
    logic                  adr_pr_q;
    logic                  adr_pr_d;
    logic                  up_q;
    logic                  up_d;
    logic                  last_q;
    logic                  last_d;
    logic                  we_q;
    logic                  we_d;
    logic                  re_q;
    logic                  re_d;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W-1:0]     wdata_d;
    logic                  busy_q;
    logic                  busy_d;
    logic                  done_q;
    logic                  done_d;

    logic                  cmp_vld_q;
    logic [DATA_W-1:0]     exp_q;
    logic [ADR_SIZE-1:0]   cmp_adr_q;
    logic [2:0]            cmp_elem_q;
    logic                  fail_q;
    logic [ADR_SIZE-1:0]   fail_adr_q;
    logic [2:0]            fail_elem_q;

    logic                  last_op;
    logic                  mismatch;
    logic                  start_ok;

    assign last_op  = (state_q == S_OP2) ||
                      ((state_q == S_OP1) && el_single(elem_q));
    assign mismatch = cmp_vld_q && (mem_rdata != exp_q);
    assign start_ok = start &&
                      ((state_q == S_IDLE) || (state_q == S_DONE));

    // Next state and element: walk elements, stepping Gen after each address.
    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_INIT;
                    elem_d  = 3'd0;
                end
            end
            S_INIT: state_d = S_OP1;
            S_OP1, S_OP2: begin
                if (!last_op) begin
                    state_d = S_OP2;
                end else if (!adr_c_out) begin
                    state_d = S_OP1;
                end else if (elem_q == LAST_ELEM) begin
                    state_d = S_FLUSH;
                end else begin
                    state_d = S_INIT;
                    elem_d  = elem_q + 3'd1;
                end
            end
            S_FLUSH: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (ABORT_ON_FAIL && mismatch) begin
            state_d = S_DONE;
        end
    end

    // Output decode for the state being entered, so every output is a flop.
    always_comb begin
        adr_rst_d = 1'b0;
        adr_pr_d  = 1'b0;
        up_d      = 1'b0;
        last_d    = 1'b0;
        we_d      = 1'b0;
        re_d      = 1'b0;
        wdata_d   = '0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        unique case (state_d)
            S_INIT: begin
                up_d      = el_up(elem_d);
                adr_rst_d = el_up(elem_d);
                adr_pr_d  = !el_up(elem_d);
                busy_d    = 1'b1;
            end
            S_OP1: begin
                up_d   = el_up(elem_d);
                busy_d = 1'b1;
                last_d = el_single(elem_d);
                if (op1_rd(elem_d)) begin
                    re_d = 1'b1;
                end else begin
                    we_d    = 1'b1;
                    wdata_d = {DATA_W{op1_bg(elem_d)}};
                end
            end
            S_OP2: begin
                up_d    = el_up(elem_d);
                busy_d  = 1'b1;
                last_d  = 1'b1;
                we_d    = 1'b1;
                wdata_d = {DATA_W{op2_bg(elem_d)}};
            end
            S_FLUSH: busy_d = 1'b1;
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            elem_q    <= '0;
            adr_rst_q <= 1'b0;
            adr_pr_q  <= 1'b0;
            up_q      <= 1'b0;
            last_q    <= 1'b0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            elem_q    <= elem_d;
            adr_rst_q <= adr_rst_d;
            adr_pr_q  <= adr_pr_d;
            up_q      <= up_d;
            last_q    <= last_d;
            we_q      <= we_d;
            re_q      <= re_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Read pipeline: capture expectation with the read, compare one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_vld_q   <= 1'b0;
            exp_q       <= '0;
            cmp_adr_q   <= '0;
            cmp_elem_q  <= '0;
            fail_q      <= 1'b0;
            fail_adr_q  <= '0;
            fail_elem_q <= '0;
        end else begin
            cmp_vld_q <= re_q && !(ABORT_ON_FAIL && mismatch);
            if (re_q) begin
                exp_q      <= {DATA_W{op1_bg(elem_q)}};
                cmp_adr_q  <= adr;
                cmp_elem_q <= elem_q;
            end
            if (start_ok) begin
                fail_q      <= 1'b0;
                fail_adr_q  <= '0;
                fail_elem_q <= '0;
            end else if (mismatch) begin
                fail_q <= 1'b1;
                if (!fail_q) begin
                    fail_adr_q  <= cmp_adr_q;
                    fail_elem_q <= cmp_elem_q;
                end
            end
        end
    end

    // Gen is only stepped off a non-terminal address, so it never wraps.
    assign adr_en      = last_q && !adr_c_out;
    assign adr_rst     = adr_rst_q;
    assign adr_pr_rst  = adr_pr_q;
    assign adr_up_down = up_q;
    assign mem_we      = we_q;
    assign mem_re      = re_q;
    assign mem_wdata   = wdata_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fail        = fail_q;
    assign fail_adr    = fail_adr_q;
    assign fail_elem   = fail_elem_q;

endmodule
